// File: rtl/spike_out_pkg.sv
// Shared types for the spike output path: the address event record and its field widths.
// The event record is sized for the default configuration; the encoder extends or truncates into it.
package spike_out_pkg;

    localparam int ADDR_WIDTH         = 1;
    localparam int DEFAULT_TIME_WIDTH = 16;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]         addr;
        logic [DEFAULT_TIME_WIDTH-1:0] ts;
    } spike_event_t;

    // Address width for a column count, never narrower than one bit.
    function automatic int addrBits(input int numCols);
        return (numCols > 1) ? $clog2(numCols) : 1;
    endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous show-ahead FIFO of spike events; dout presents the head entry whenever empty is low.
module spike_event_fifo
    import spike_out_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  spike_event_t din,
    output logic         full,
    input  logic         pop,
    output spike_event_t dout,
    output logic         empty,
    output logic [PW:0]  count
);

    spike_event_t r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [PW:0]   r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign full     = (r_count == (PW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign dout     = r_mem[r_rdPtr];
    assign w_doPush = push && !full;
    assign w_doPop  = pop && !empty;

    // Storage carries no reset; an empty count makes stale contents invisible.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spike_out_encoder.sv
// Timestamps neuron column spikes, arbitrates them round-robin into an event FIFO and streams them out.
// Optional drop counter port drop_cnt is enabled by defining SPIKE_OUT_DROP_CNT_EN.
module spike_out_encoder
    import spike_out_pkg::*;
#(
    parameter int NUM_COLS   = 2,
    parameter int TIME_WIDTH = DEFAULT_TIME_WIDTH,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = addrBits(NUM_COLS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_COLS-1:0]   spike,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AW-1:0]         out_addr,
    output logic [TIME_WIDTH-1:0] out_time,
    output logic                  overflow,
    input  logic                  clear_overflow
`ifdef SPIKE_OUT_DROP_CNT_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    logic [TIME_WIDTH-1:0] r_ts;
    logic [NUM_COLS-1:0]   r_pending;
    logic [TIME_WIDTH-1:0] r_ptime [NUM_COLS];
    logic [AW-1:0]         r_rr;
    logic                  r_overflow;
    logic [AW-1:0]         r_lastAddr;
    logic [TIME_WIDTH-1:0] r_lastTime;

    logic                  w_found;
    logic [AW-1:0]         w_grantIdx;
    logic                  w_grant;
    logic [NUM_COLS-1:0]   w_grantMask;
    logic [NUM_COLS-1:0]   w_drop;
    logic [AW-1:0]         w_rrNext;
    spike_event_t          w_pushEvt;
    spike_event_t          w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                  w_pop;

    // Round-robin search starting at the pointer; a grant also needs a free FIFO slot as of this cycle.
    always_comb begin
        int idx;
        idx        = 0;
        w_found    = 1'b0;
        w_grantIdx = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            idx = (int'(r_rr) + i) % NUM_COLS;
            if (!w_found && r_pending[AW'(idx)]) begin
                w_found    = 1'b1;
                w_grantIdx = AW'(idx);
            end
        end
    end

    assign w_grant  = w_found && (int'(w_count) < FIFO_DEPTH);
    assign w_rrNext = AW'((int'(w_grantIdx) + 1) % NUM_COLS);

    always_comb begin
        w_grantMask = '0;
        if (w_grant) begin
            w_grantMask[w_grantIdx] = 1'b1;
        end
    end

    assign w_drop = spike & r_pending & ~w_grantMask;

    always_comb begin
        w_pushEvt      = '0;
        w_pushEvt.addr = ADDR_WIDTH'(w_grantIdx);
        w_pushEvt.ts   = DEFAULT_TIME_WIDTH'(r_ptime[w_grantIdx]);
    end

    spike_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_grant && !w_full),
        .din   (w_pushEvt),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_head),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_pop     = out_valid && out_ready;
    assign out_valid = !w_empty;
    assign out_addr  = w_empty ? r_lastAddr : AW'(w_head.addr);
    assign out_time  = w_empty ? r_lastTime : TIME_WIDTH'(w_head.ts);
    assign overflow  = r_overflow;

    // A spike landing on a column that is being granted this cycle re-arms it rather than dropping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts       <= '0;
            r_pending  <= '0;
            r_rr       <= '0;
            r_overflow <= 1'b0;
            r_lastAddr <= '0;
            r_lastTime <= '0;
            for (int c = 0; c < NUM_COLS; c++) begin
                r_ptime[c] <= '0;
            end
        end else begin
            r_ts      <= r_ts + 1'b1;
            r_pending <= spike | (r_pending & ~w_grantMask);
            if (w_grant) begin
                r_rr <= w_rrNext;
            end
            r_overflow <= (|w_drop) || (r_overflow && !clear_overflow);
            if (w_pop) begin
                r_lastAddr <= AW'(w_head.addr);
                r_lastTime <= TIME_WIDTH'(w_head.ts);
            end
            for (int c = 0; c < NUM_COLS; c++) begin
                if (spike[c] && !w_drop[c]) begin
                    r_ptime[c] <= r_ts;
                end
            end
        end
    end

`ifdef SPIKE_OUT_DROP_CNT_EN
    logic [7:0]  r_dropCnt;
    logic [15:0] w_dropSum;

    // Clearing and dropping in the same cycle leaves just this cycle's drops counted.
    assign w_dropSum = (clear_overflow ? 16'd0 : {8'd0, r_dropCnt}) + 16'($countones(w_drop));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dropCnt <= '0;
        end else begin
            r_dropCnt <= (w_dropSum > 16'd255) ? 8'd255 : w_dropSum[7:0];
        end
    end

    assign drop_cnt = r_dropCnt;
`endif

endmodule
